// File: rtl/session_pkg.sv
// session_pkg: shared state encoding and frame constants for the play-session sequencer
package session_pkg;
  localparam int TIME_W = 16;
  localparam int SONG_FRAMES_DEF = 5596;
  localparam int COUNTDOWN_FRAMES_DEF = 180;
  localparam int RESULT_FRAMES_DEF = 300;
  typedef enum logic [2:0] {IDLE, COUNTDOWN, PLAYING, PAUSED, RESULTS} session_state_t;
endpackage

// File: rtl/session_sequencer_rise_detect.sv
// rise_detect: one-cycle rising-edge strobe from a synchronous level, history cleared on reset
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk) prev <= reset ? 1'b0 : d;
  assign rise = d & ~prev;
endmodule

// File: rtl/session_sequencer.sv
// session_sequencer: frame-driven countdown/play/pause/results FSM with note-fetch handshake
module session_sequencer
  import session_pkg::*;
#(
  parameter int SONG_FRAMES = SONG_FRAMES_DEF,
  parameter int COUNTDOWN_FRAMES = COUNTDOWN_FRAMES_DEF,
  parameter int RESULT_FRAMES = RESULT_FRAMES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_frame,
  input  logic                start_btn,
  input  logic                pause_btn,
  input  logic                fetch_ack,
  output session_state_t      state,
  output logic [TIME_W-1:0]   song_time,
  output logic [7:0]          countdown,
  output logic                playing,
  output logic                frame_tick,
  output logic                fetch_req,
  output logic                done,
  output logic                overrun
);
  logic frame_e, start_e, pause_e;
  logic at_last, cd_last, res_last, tick_n, done_n;
  logic [15:0] res_cnt;
  session_state_t state_n;
  rise_detect u_frame (.clk(clk), .reset(reset), .d(new_frame), .rise(frame_e));
  rise_detect u_start (.clk(clk), .reset(reset), .d(start_btn), .rise(start_e));
  rise_detect u_pause (.clk(clk), .reset(reset), .d(pause_btn), .rise(pause_e));
  assign at_last  = song_time == TIME_W'(SONG_FRAMES - 1);
  assign cd_last  = countdown == 8'd1;
  assign res_last = res_cnt == 16'(RESULT_FRAMES - 1);
  // start always wins; a frame at the last song frame outranks a same-cycle pause
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = start_e ? COUNTDOWN : IDLE;
      COUNTDOWN: state_n = start_e ? IDLE : (frame_e && cd_last) ? PLAYING : COUNTDOWN;
      PLAYING:   state_n = start_e ? IDLE : (frame_e && at_last) ? RESULTS : pause_e ? PAUSED : PLAYING;
      PAUSED:    state_n = start_e ? IDLE : pause_e ? PLAYING : PAUSED;
      RESULTS:   state_n = (start_e || (frame_e && res_last)) ? IDLE : RESULTS;
      default:   state_n = IDLE;
    endcase
    tick_n = !start_e && frame_e && ((state == COUNTDOWN && cd_last) || (state == PLAYING && !at_last));
    done_n = !start_e && frame_e && state == PLAYING && at_last;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      song_time  <= '0;
      countdown  <= '0;
      res_cnt    <= '0;
      frame_tick <= 1'b0;
      done       <= 1'b0;
      fetch_req  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      frame_tick <= tick_n;
      done       <= done_n;
      song_time  <= state_n == IDLE ? '0 : (tick_n && state == PLAYING) ? song_time + 1'b1 : song_time;
      countdown  <= state_n == IDLE ? 8'd0 : state == IDLE ? 8'(COUNTDOWN_FRAMES) :
                    (state == COUNTDOWN && frame_e) ? countdown - 8'd1 : countdown;
      res_cnt    <= state != RESULTS ? 16'd0 : frame_e ? res_cnt + 16'd1 : res_cnt;
      fetch_req  <= state_n == IDLE ? 1'b0 : tick_n | (fetch_req & ~fetch_ack);
      overrun    <= (state == IDLE && start_e) ? 1'b0 : overrun | (tick_n & fetch_req & ~fetch_ack);
    end
  end
  always_comb playing = state == PLAYING;
endmodule

// File: tb/tb_session_sequencer.sv
// tb_session_sequencer: directed vectors with hand-computed expectations for SONG=5, COUNTDOWN=2, RESULT=3
module tb_session_sequencer;
  import session_pkg::*;
  logic clk = 0, reset = 1, new_frame = 0, start_btn = 0, pause_btn = 0, fetch_ack = 0;
  session_state_t state;
  logic [15:0] song_time;
  logic [7:0] countdown;
  logic playing, frame_tick, fetch_req, done, overrun;
  int n_tests = 0, n_fail = 0;
  session_sequencer #(.SONG_FRAMES(5), .COUNTDOWN_FRAMES(2), .RESULT_FRAMES(3)) dut (
    .clk(clk), .reset(reset), .new_frame(new_frame), .start_btn(start_btn), .pause_btn(pause_btn),
    .fetch_ack(fetch_ack), .state(state), .song_time(song_time), .countdown(countdown),
    .playing(playing), .frame_tick(frame_tick), .fetch_req(fetch_req), .done(done), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input bit f, input bit s, input bit p);
    new_frame = f;
    start_btn = s;
    pause_btn = p;
    step();
  endtask
  task automatic to_playing();
    drive(0, 1, 0);
    drive(0, 0, 0);
    drive(1, 0, 0);
    drive(0, 0, 0);
    drive(1, 0, 0);
    drive(0, 0, 0);
  endtask
  initial begin
    step();
    step();
    reset = 0;
    step();
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_time", 32'(song_time), 0);
    chk("rst_cd", 32'(countdown), 0);
    chk("rst_flags", {playing, frame_tick, fetch_req, done, overrun}, 0);
    fetch_ack = 1;
    drive(0, 1, 0);
    chk("start_state", 32'(state), 32'(COUNTDOWN));
    chk("start_cd", 32'(countdown), 2);
    drive(0, 0, 0);
    drive(1, 0, 0);
    chk("cd1", 32'(countdown), 1);
    chk("cd1_state", 32'(state), 32'(COUNTDOWN));
    drive(0, 0, 0);
    drive(1, 0, 0);
    chk("play_state", 32'(state), 32'(PLAYING));
    chk("play_cd", 32'(countdown), 0);
    chk("play_time", 32'(song_time), 0);
    chk("play_tick_req", {playing, frame_tick, fetch_req}, 3'b111);
    drive(1, 0, 0);
    chk("held_frame_no_tick", 32'(frame_tick), 0);
    chk("req_acked", 32'(fetch_req), 0);
    drive(0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 0);
      chk("adv_time", 32'(song_time), 32'(i));
      chk("adv_tick", 32'(frame_tick), 1);
      drive(0, 0, 0);
    end
    drive(1, 0, 0);
    chk("done_pulse", 32'(done), 1);
    chk("results_state", 32'(state), 32'(RESULTS));
    chk("results_time", 32'(song_time), 4);
    chk("results_tick", 32'(frame_tick), 0);
    drive(0, 0, 0);
    chk("done_one_cycle", 32'(done), 0);
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 0);
      chk("results_hold", 32'(state), i < 3 ? 32'(RESULTS) : 32'(IDLE));
      drive(0, 0, 0);
    end
    chk("idle_time_cleared", 32'(song_time), 0);
    chk("no_overrun", 32'(overrun), 0);
    to_playing();
    drive(1, 0, 0);
    drive(0, 0, 0);
    drive(1, 0, 0);
    drive(0, 0, 0);
    chk("pre_pause_time", 32'(song_time), 2);
    drive(0, 0, 1);
    chk("paused_state", 32'(state), 32'(PAUSED));
    chk("paused_playing", 32'(playing), 0);
    drive(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0);
      chk("paused_frozen", {16'(song_time), 15'd0, frame_tick}, {16'd2, 16'd0});
      drive(0, 0, 0);
    end
    drive(0, 0, 1);
    chk("resume_state", 32'(state), 32'(PLAYING));
    chk("resume_no_tick", 32'(frame_tick), 0);
    drive(0, 0, 0);
    drive(1, 0, 0);
    chk("resume_adv", 32'(song_time), 3);
    drive(0, 0, 0);
    drive(0, 1, 0);
    chk("abort_state", 32'(state), 32'(IDLE));
    chk("abort_time", 32'(song_time), 0);
    drive(0, 0, 0);
    to_playing();
    drive(1, 0, 0);
    drive(0, 0, 0);
    drive(1, 0, 1);
    chk("sim_time", 32'(song_time), 2);
    chk("sim_tick", 32'(frame_tick), 1);
    chk("sim_state", 32'(state), 32'(PAUSED));
    drive(0, 0, 0);
    drive(0, 0, 1);
    drive(0, 0, 0);
    drive(1, 1, 0);
    chk("start_wins_state", 32'(state), 32'(IDLE));
    chk("start_wins_tick", {frame_tick, fetch_req}, 0);
    chk("start_wins_time", 32'(song_time), 0);
    drive(0, 0, 0);
    fetch_ack = 0;
    to_playing();
    chk("req_pending", 32'(fetch_req), 1);
    drive(1, 0, 0);
    chk("ovr_set", {fetch_req, overrun}, 2'b11);
    chk("ovr_time", 32'(song_time), 1);
    drive(0, 0, 0);
    fetch_ack = 1;
    step();
    chk("ack_drops_req", 32'(fetch_req), 0);
    chk("ovr_sticky", 32'(overrun), 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0);
      drive(0, 0, 0);
    end
    chk("ovr_results_state", 32'(state), 32'(RESULTS));
    chk("ovr_results", 32'(overrun), 1);
    drive(0, 1, 0);
    chk("ovr_idle_kept", {4'(state), 3'd0, overrun}, {4'(IDLE), 4'd1});
    drive(0, 0, 0);
    drive(0, 1, 0);
    chk("ovr_cleared", 32'(overrun), 0);
    drive(0, 0, 0);
    fetch_ack = 0;
    drive(1, 0, 0);
    drive(0, 0, 0);
    drive(1, 0, 0);
    chk("pre_reset_req", {playing, fetch_req}, 2'b11);
    reset = 1;
    drive(0, 1, 0);
    chk("mid_reset_state", 32'(state), 32'(IDLE));
    chk("mid_reset_vals", {16'(song_time), 8'(countdown), 3'd0, playing, frame_tick, fetch_req, done, overrun}, 0);
    step();
    reset = 0;
    step();
    chk("held_start_state", 32'(state), 32'(COUNTDOWN));
    chk("held_start_cd", 32'(countdown), 2);
    step();
    chk("held_start_once", 32'(countdown), 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/session_sequencer.md
# session_sequencer

Top-level play-session controller for the rhythm-game frame timeline. Converts the per-frame strobe into a countdown, a pausable song clock `song_time`, and a results hold period. Issues one note-fetch request per played frame to the note/chart memory over a req/ack handshake. Sits between the video timing generator (frame strobe), the keypad/button front end, and the chart reader and scoring logic.

## Interface
- `SONG_FRAMES`, default 5596: played frames; `song_time` runs 0..SONG_FRAMES-1.
- `COUNTDOWN_FRAMES`, default 180: pre-roll frames (3 s at 60 Hz), range 1..255.
- `RESULT_FRAMES`, default 300: results-screen hold frames, range 1..65535.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; clock `clk`.
- `new_frame`  in  1  frame strobe, synchronous to `clk`, may stay high many cycles; only its rising edge counts.
- `start_btn`  in  1  start/abort button, synchronous level; rising edge used.
- `pause_btn`  in  1  pause toggle button, synchronous level; rising edge used.
- `fetch_ack`  in  1  chart memory accepted the current request.
- `state`  out  3  encoded session state (package enum).
- `song_time`  out  16  current played frame index.
- `countdown`  out  8  remaining pre-roll frames.
- `playing`  out  1  high in PLAYING only.
- `frame_tick`  out  1  one-cycle pulse when `song_time` takes a new value in PLAYING.
- `fetch_req`  out  1  note fetch request for `song_time`.
- `done`  out  1  one-cycle pulse on PLAYING→RESULTS.
- `overrun`  out  1  sticky: a frame arrived while `fetch_req` still pending.

## Operation
- Rising edges: each of `new_frame`, `start_btn`, `pause_btn` has a 1-flop history; edge = in & ~prev. History flops clear to 0 on reset, so an input high at reset release produces an edge.
- IDLE: `start` edge → COUNTDOWN, `countdown`=COUNTDOWN_FRAMES. Pause ignored.
- COUNTDOWN: each frame edge decrements `countdown`. Frame edge with `countdown`==1 → PLAYING, `countdown`=0, `song_time`=0, `frame_tick`=1. Start edge aborts → IDLE. Pause ignored.
- PLAYING: frame edge with `song_time` < SONG_FRAMES-1 → `song_time`+1, `frame_tick`. Frame edge at SONG_FRAMES-1 → RESULTS, `done` pulse, `song_time` holds. Pause edge → PAUSED. Start edge → IDLE.
- Simultaneous frame and pause edge in PLAYING: frame is applied, tick and fetch issued, then state = PAUSED. Simultaneous start and anything: start wins, returns to IDLE.
- PAUSED: `song_time` frozen, frames ignored. Pause edge → PLAYING with no tick; next frame edge advances. Start edge → IDLE.
- RESULTS: an internal 16-bit counter counts frames. When RESULT_FRAMES frames have elapsed, or on a start edge → IDLE.
- Entering IDLE from any state clears `song_time`, `countdown`, `fetch_req`. `overrun` clears only on reset or the IDLE→COUNTDOWN transition.
- Fetch handshake:
  - `fetch_req` sets with every `frame_tick`.
  - Clears on the cycle after `fetch_ack` is sampled high while req is high.
  - A `frame_tick` while req is still high (ack not yet seen) keeps req high and sets `overrun`. The time still advances and the requested address is the new `song_time`.
  - Ack with req low is ignored.
- Width: `song_time` never wraps; saturates at SONG_FRAMES-1.

## Timing
- Reset values: state=IDLE, `song_time`=0, `countdown`=0, `playing`/`frame_tick`/`fetch_req`/`done`/`overrun`=0.
- All outputs are registered. An edge sampled at cycle N is visible at cycle N+1, e.g. `new_frame` 0→1 at N gives `frame_tick` and new `song_time` at N+1.
- `fetch_req` rises together with `frame_tick`. `fetch_ack` high at cycle M drops req at M+1. Minimum req pulse is 1 cycle.
- Reset mid-session: next cycle every output is at its reset value regardless of state.

## Structure
- `session_pkg`: `session_state_t` enum (IDLE, COUNTDOWN, PLAYING, PAUSED, RESULTS), default frame constants, `TIME_W`=16.
- Sub-module `rise_detect`: 1-bit edge detector with synchronous reset, instantiated three times.
- The FSM, counters and handshake register live in `session_sequencer`.

## Test plan
Small parameters for all scenarios: SONG_FRAMES=5, COUNTDOWN_FRAMES=2, RESULT_FRAMES=3.
- Start edge, then 2 frame edges → `countdown` 2→1→0, PLAYING, `song_time`=0, `frame_tick` and `fetch_req` high one cycle after the 2nd edge.
- Play with immediate acks, 4 more frames → `song_time` 1..4; a 5th frame gives `done`=1 for one cycle, RESULTS, `song_time`=4; 3 more frames → IDLE, `song_time`=0.
- Pause edge at `song_time`=2, then 3 frames → `song_time` stays 2, no ticks. Pause again, then frame → 3.
- Frame and pause edges in the same cycle at `song_time`=1 → next cycle `song_time`=2, tick, state PAUSED.
- Withhold ack across two frames → `fetch_req` stays high, `overrun`=1 sticky through RESULTS; start edge from IDLE clears it.
- Reset asserted mid-PLAYING with req pending, or `start_btn` high at reset release → reset values after 1 cycle; the held button starts a countdown once reset drops.
